// File: rtl/sha1_pkg.sv
// Shared constants, round helpers and FSM state type for the SHA-1 compression engine.
package sha1_pkg;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hEFCDAB89;
    localparam logic [31:0] IV2 = 32'h98BADCFE;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hC3D2E1F0;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    localparam int unsigned Rounds = 80;

    typedef enum logic [1:0] {StIdle, StBusy, StFinish} state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] f_round(input logic [6:0] t, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20) begin
            return (b & c) | (~b & d);
        end else if (t < 7'd40) begin
            return b ^ c ^ d;
        end else if (t < 7'd60) begin
            return (b & c) | (b & d) | (c & d);
        end
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] k_const(input logic [6:0] t);
        if (t < 7'd20) begin
            return K0;
        end else if (t < 7'd40) begin
            return K1;
        end else if (t < 7'd60) begin
            return K2;
        end
        return K3;
    endfunction

endpackage

// File: rtl/sha1_w_schedule.sv
// 16-word message schedule window: loaded from the block, expanded by one word per round.
module sha1_w_schedule
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block,
    output logic [31:0]  wt
);

    logic [31:0] win_q [16];
    logic [31:0] w_new;

    // win_q[k] holds W[t+k]; the appended word is W[t+16].
    assign w_new = rotl(win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0], 1);
    assign wt    = win_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= block[511-32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha1_block.sv
// Iterative SHA-1 compression: one round per clock over 80 rounds, then the feed-forward add.
module sha1_block
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [159:0] context_in,
    input  logic [511:0] block,
    output logic         done,
    output logic [159:0] context_out
);

    state_e       state_q, state_d;
    logic [6:0]   t_q;
    logic [159:0] h_q;
    logic [31:0]  a_q, b_q, c_q, d_q, e_q;
    logic [159:0] ctx_q;
    logic         done_q;

    logic         accept;
    logic         round_en;
    logic         finish;
    logic [31:0]  wt;
    logic [31:0]  temp;

    sha1_w_schedule u_w_schedule (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (round_en),
        .block (block),
        .wt    (wt)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        round_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                round_en = 1'b1;
                if (t_q == 7'(Rounds - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                finish  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign temp = rotl(a_q, 5) + f_round(t_q, b_q, c_q, d_q) + e_q + k_const(t_q) + wt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            t_q     <= '0;
            h_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            ctx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                h_q    <= context_in;
                a_q    <= context_in[159:128];
                b_q    <= context_in[127:96];
                c_q    <= context_in[95:64];
                d_q    <= context_in[63:32];
                e_q    <= context_in[31:0];
                t_q    <= '0;
                done_q <= 1'b0;
            end else if (round_en) begin
                e_q <= d_q;
                d_q <= c_q;
                c_q <= rotl(b_q, 30);
                b_q <= a_q;
                a_q <= temp;
                t_q <= t_q + 7'd1;
            end else if (finish) begin
                // Each word wraps independently; no carry crosses word boundaries.
                ctx_q  <= {h_q[159:128] + a_q, h_q[127:96] + b_q, h_q[95:64] + c_q,
                           h_q[63:32] + d_q, h_q[31:0] + e_q};
                done_q <= 1'b1;
            end
        end
    end

    assign done        = done_q;
    assign context_out = ctx_q;

endmodule

// File: tb/tb_sha1_block.sv
// Scoreboard bench for sha1_block: known digests plus random blocks against a plain SHA-1 model.
module tb_sha1_block;
    import sha1_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [159:0] context_in;
    logic [511:0] block;
    logic         done;
    logic [159:0] context_out;

    sha1_block dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .context_in  (context_in),
        .block       (block),
        .done        (done),
        .context_out (context_out)
    );

    typedef struct {
        logic [159:0] ctx;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic done_prev;

    localparam logic [159:0] Iv = {IV0, IV1, IV2, IV3, IV4};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [159:0] sha1_ref(input logic [159:0] ctx, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, x, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {x[30:0], x[31]};
        end
        a = ctx[159:128]; b = ctx[127:96]; c = ctx[95:64]; d = ctx[63:32]; e = ctx[31:0];
        for (int t = 0; t < 80; t++) begin
            if (t < 20) begin
                f = (b & c) | (~b & d); k = 32'h5A827999;
            end else if (t < 40) begin
                f = b ^ c ^ d; k = 32'h6ED9EBA1;
            end else if (t < 60) begin
                f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
            end else begin
                f = b ^ c ^ d; k = 32'hCA62C1D6;
            end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {ctx[159:128] + a, ctx[127:96] + b, ctx[95:64] + c, ctx[63:32] + d,
                ctx[31:0] + e};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [159:0] rand160();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Monitor: every rising edge of done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 160'd1, 160'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("digest", context_out, e.ctx);
                    check("latency", 160'(cyc - e.acc), 160'd81);
                end
            end
            done_prev = done;
        end
    end

    task automatic run_block(input logic [159:0] ctx, input logic [511:0] blk, input int hold,
                             input logic [159:0] expv);
        exp_t e;
        @(negedge clk);
        context_in = ctx;
        block      = blk;
        start      = 1'b1;
        e.ctx      = expv;
        e.acc      = cyc + 1;
        exp_q.push_back(e);
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 160'(exp_q.size()), 160'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [511:0] blk, blk2;
        logic [159:0] ctx, last_exp;
        logic [439:0] s55;
        logic [447:0] s56;

        rst_n      = 1'b0;
        start      = 1'b0;
        context_in = '0;
        block      = '0;
        repeat (3) @(negedge clk);
        check("reset_done", {159'b0, done}, 160'd0);
        check("reset_ctx", context_out, 160'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty message, start held for three cycles.
        blk = {8'h80, 504'b0};
        run_block(Iv, blk, 3, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
        wait_idle();
        repeat (5) @(negedge clk);
        check("done_holds", {159'b0, done}, 160'd1);

        blk = {24'h616263, 8'h80, 416'b0, 64'd24};
        run_block(Iv, blk, 1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        wait_idle();

        s55 = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ012";
        blk = {s55, 8'h80, 64'd440};
        run_block(Iv, blk, 5, sha1_ref(Iv, blk));
        wait_idle();

        s56  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        blk  = {s56, 8'h80, 56'b0};
        blk2 = {448'b0, 64'd448};
        run_block(Iv, blk, 1, sha1_ref(Iv, blk));
        wait_idle();
        run_block(context_out, blk2, 1, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            ctx = rand160();
            blk = rand512();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_block(ctx, blk, int'($urandom_range(1, 3)), sha1_ref(ctx, blk));
            wait_idle();
        end

        // Abort mid-run with asynchronous reset, then a clean full run.
        ctx = rand160();
        blk = rand512();
        run_block(ctx, blk, 1, sha1_ref(ctx, blk));
        repeat (39) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_done", {159'b0, done}, 160'd0);
        check("abort_ctx", context_out, 160'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        blk = {24'h616263, 8'h80, 416'b0, 64'd24};
        run_block(Iv, blk, 1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        wait_idle();

        // Inputs changing while busy; old result held until the new one lands.
        last_exp = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
        ctx = rand160();
        blk = rand512();
        run_block(ctx, blk, 1, sha1_ref(ctx, blk));
        check("done_drops", {159'b0, done}, 160'd0);
        check("ctx_held_start", context_out, last_exp);
        context_in = rand160();
        block      = rand512();
        repeat (40) @(negedge clk);
        check("ctx_held_busy", context_out, last_exp);
        context_in = rand160();
        block      = rand512();
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha1_block.md
Name: sha1_block

Overview:
- Iterative SHA-1 compression engine: processes one pre-padded 512-bit message block against a 160-bit chaining context.
- Performs one round per clock, 80 rounds, then the final Davies–Meyer addition.
- Padding and multi-block chaining are the caller's job: it feeds the previous `context_out` back as `context_in`.

Parameters:
- None. Word size 32, rounds 80 and block size 512 are fixed by FIPS 180-4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level request; sampled at a clock edge when the engine is not busy
- context_in  input  160  chaining value {H0,H1,H2,H3,H4}, H0 in [159:128]
- block  input  512  padded message block, word W0 in [511:480], big-endian words
- done  output  1  result valid; high from completion until the next accepted start
- context_out  output  160  updated chaining value {H0..H4}, H0 in [159:128]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, round counter=0, done=0, context_out=0.
  - Reset mid-operation aborts the block; no partial result is ever shown.
- States: IDLE, BUSY, FINISH.
- Accept: on a clk edge with start=1 and state≠BUSY/FINISH (IDLE, or IDLE with done=1):
  - latch context_in into H regs and into a..e;
  - load the 16-word schedule window from block;
  - round counter t=0, done←0, state→BUSY.
- context_in and block are sampled only at accept. They may change afterwards without effect.
- start while BUSY/FINISH is ignored. Holding start high for several cycles therefore starts exactly one operation.
- BUSY: one round per edge, t=0..79:
  - Wt = window head for t<16; for t≥16, Wt = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
  - Implemented as a 16×32 shift register; the new word is appended each round.
  - Round function and constant by t:
    - t 0–19: f=(b&c)|(~b&d), K=5A827999.
    - t 20–39: f=b^c^d, K=6ED9EBA1.
    - t 40–59: f=(b&c)|(b&d)|(c&d), K=8F1BBCDC.
    - t 60–79: f=b^c^d, K=CA62C1D6.
  - temp=rotl5(a)+f+e+K+Wt (mod 2^32); e←d; d←c; c←rotl30(b); b←a; a←temp.
  - After round 79 → FINISH.
- FINISH (one edge):
  - context_out ← {H0+a, H1+b, H2+c, H3+d, H4+e}, each mod 2^32;
  - done←1; state→IDLE.
- Latency: accept edge T; rounds on edges T+1..T+80; done=1 and context_out valid after edge T+81.
- context_out holds its last value, including during a following operation, until the next FINISH. done is the only validity qualifier.
- All additions 32-bit wrap-around; no carries between words.

Decomposition:
- Package sha1_pkg:
  - IV constants 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0;
  - the four K constants;
  - rotl function;
  - f(t,b,c,d) function;
  - state enum.
- One natural sub-module: sha1_w_schedule (16-word window; load from block, shift and expand per round, Wt output).
- Round datapath and FSM stay in sha1_block.

Test Plan:
- Empty message: block={80h,0…0}, context_in=IV, start held 3 cycles → exactly one run; done=1 after edge T+81; context_out=da39a3ee5e6b4b0d3255bfef95601890afd80709.
- "abc": block={"abc",80h,416'b0,64'd24}, IV → a9993e364706816aba3e25717850c26c9cd0d89d.
- 55-char string "abc…XYZ012" with 80h and length 440 → context_out matches a software SHA-1 model; start held high does not retrigger.
- Two-block chaining with "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": feed first result as context_in of the second padded block → 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- Reset checks:
  - assert rst_n at round ~40 → done=0 and context_out=0 immediately;
  - next start produces a correct, full-latency result.
- Input stability: change block/context_in during BUSY → result unaffected; done drops on the next accepted start while context_out holds the old value until FINISH.
